seq_mac_alu: RTL

SEQ_MAC_ALU -- requirements
Module: seq_mac_alu

---
 rtl/alu_pkg.sv | 19 +
 rtl/seq_booth_mul.sv | 58 +++++
 rtl/seq_mac_alu.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential MAC/ALU: controller states, default
// geometry and the signed-add overflow helper.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      WB   = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_FRAC  = 3;

   // Two's complement add overflows when both operands share a sign the sum lacks.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/seq_booth_mul.sv
// Sequential signed radix-2 Booth multiplier: load captures the operands,
// each step retires one multiplier bit; product is valid after WIDTH steps.
module seq_booth_mul #(
   parameter int WIDTH = 8
) (
   input  logic               Clock,
   input  logic               nReset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   mcand,
   input  logic [WIDTH-1:0]   mplier,
   output logic [2*WIDTH-1:0] product
);

   logic [WIDTH-1:0] m_r;
   logic [WIDTH:0]   a_r;
   logic [WIDTH-1:0] q_r;
   logic             qm1_r;

   logic [WIDTH:0]   m_ext_s;
   logic [WIDTH:0]   addsub_s;
   logic [WIDTH:0]   a_nxt_s;
   logic [WIDTH-1:0] q_nxt_s;
   logic             qm1_nxt_s;

   // Booth recode, add/subtract into the guard-extended high half, then arithmetic shift.
   always_comb begin
      m_ext_s = {m_r[WIDTH-1], m_r};
      case ({q_r[0], qm1_r})
         2'b01:   addsub_s = a_r + m_ext_s;
         2'b10:   addsub_s = a_r - m_ext_s;
         default: addsub_s = a_r;
      endcase
      {a_nxt_s, q_nxt_s, qm1_nxt_s} = {addsub_s[WIDTH], addsub_s, q_r};
   end

   // Iteration registers.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         m_r   <= '0;
         a_r   <= '0;
         q_r   <= '0;
         qm1_r <= 1'b0;
      end else if (load) begin
         m_r   <= mcand;
         a_r   <= '0;
         q_r   <= mplier;
         qm1_r <= 1'b0;
      end else if (step) begin
         a_r   <= a_nxt_s;
         q_r   <= q_nxt_s;
         qm1_r <= qm1_nxt_s;
      end
   end

   assign product = {a_r[WIDTH-1:0], q_r};

endmodule

// File: rtl/seq_mac_alu.sv
// Sequential multiply-accumulate ALU: selected operand plus optional ACC,
// optionally scaled by a fixed-point Imm, written back to ACC with overflow.
module seq_mac_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC,
   parameter int SAT   = 0
) (
   input  logic             Clock,
   input  logic             nReset,
   input  logic [WIDTH-1:0] Imm,
   input  logic [WIDTH-1:0] RegData,
   input  logic [WIDTH-1:0] SW,
   input  logic             SelImm,
   input  logic             SelSW,
   input  logic             SelRegData,
   input  logic             UseACC,
   input  logic             UseMul,
   input  logic             Start,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ACC,
   output logic             Ovf
);

   localparam int            CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t                 state_r, state_nxt_s;
   logic [CW-1:0]          cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0]       data_s, addend_s, sum_s, sum_r;
   logic                   add_ovf_s, add_ovf_r, use_mul_r;
   logic                   load_s, step_s, wr_s;
   logic [2*WIDTH-1:0]     product_s;
   logic signed [2*WIDTH-1:0] shifted_s;
   logic                   fits_s;
   logic [WIDTH-1:0]       result_s;
   logic                   ovf_s;
   logic [WIDTH-1:0]       acc_r;
   logic                   ovf_r, done_r, busy_r;

   // Operand mux (wired OR, no priority) and pre-add.
   always_comb begin
      data_s = ({WIDTH{SelImm}} & Imm) | ({WIDTH{SelSW}} & SW) | ({WIDTH{SelRegData}} & RegData);
      if (UseACC) begin
         addend_s = acc_r;
      end else begin
         addend_s = '0;
      end
      sum_s     = addend_s + data_s;
      add_ovf_s = add_ovf(addend_s[WIDTH-1], data_s[WIDTH-1], sum_s[WIDTH-1]);
   end

   // Controller: next state and per-cycle strobes.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      load_s      = 1'b0;
      step_s      = 1'b0;
      wr_s        = 1'b0;
      case (state_r)
         IDLE: begin
            if (Start) begin
               load_s      = 1'b1;
               cnt_nxt_s   = '0;
               state_nxt_s = UseMul ? MUL : WB;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         MUL: begin
            step_s = 1'b1;
            if (cnt_r == CNT_LAST) begin
               cnt_nxt_s   = '0;
               state_nxt_s = WB;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         WB: begin
            wr_s        = 1'b1;
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = '0;
         end
      endcase
   end

   seq_booth_mul #(.WIDTH(WIDTH)) u_booth (
      .Clock   (Clock),
      .nReset  (nReset),
      .load    (load_s),
      .step    (step_s),
      .mcand   (sum_s),
      .mplier  (Imm),
      .product (product_s)
   );

   // Fixed-point rescale: floor shift, then range check against signed WIDTH bits.
   always_comb begin
      shifted_s = $signed(product_s) >>> FRAC;
      fits_s    = (&shifted_s[2*WIDTH-1:WIDTH-1]) | ~(|shifted_s[2*WIDTH-1:WIDTH-1]);
      if (!use_mul_r) begin
         result_s = sum_r;
         ovf_s    = add_ovf_r;
      end else if (fits_s) begin
         result_s = shifted_s[WIDTH-1:0];
         ovf_s    = add_ovf_r;
      end else begin
         ovf_s = 1'b1;
         if (SAT != 0) begin
            result_s = shifted_s[2*WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
         end else begin
            result_s = shifted_s[WIDTH-1:0];
         end
      end
   end

   // State and MUL cycle counter.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Operands frozen at acceptance so later input changes are ignored.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         sum_r     <= '0;
         add_ovf_r <= 1'b0;
         use_mul_r <= 1'b0;
      end else if (load_s) begin
         sum_r     <= sum_s;
         add_ovf_r <= add_ovf_s;
         use_mul_r <= UseMul;
      end
   end

   // Registered outputs; ACC and Ovf change only on the write-back edge.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         acc_r  <= '0;
         ovf_r  <= 1'b0;
         done_r <= 1'b0;
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != IDLE);
         done_r <= wr_s;
         if (wr_s) begin
            acc_r <= result_s;
            ovf_r <= ovf_s;
         end
      end
   end

   assign ACC  = acc_r;
   assign Ovf  = ovf_r;
   assign Done = done_r;
   assign Busy = busy_r;

endmodule
